// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, sequencer state encoding and the
// register-write qualification helper used by the sequencer and decoder.
package cpu_pkg;

  localparam logic [3:0] OP_CCOPY  = 4'h3;
  localparam logic [3:0] OP_UNUSED = 4'hC;
  localparam logic [3:0] OP_JUMP   = 4'hD;
  localparam logic [3:0] OP_HALT   = 4'hE;
  localparam logic [3:0] OP_CHALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXECUTE,
    ST_PAUSE,
    ST_HALTED
  } seq_state_t;

  // Whether an executing instruction may write the register file.
  // Conditional copy resolves against the live register value.
  function automatic logic op_write_enable(input logic [3:0] op, input logic cond_nz);
    logic we;
    case (op)
      OP_CCOPY:                                    we = cond_nz;
      OP_UNUSED, OP_JUMP, OP_HALT, OP_CHALT:       we = 1'b0;
      default:                                     we = 1'b1;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Next count: clear, else increment until all-ones then hold.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/program_sequencer.sv
// Execution controller: owns the PC and the fetch/execute FSM, resolves
// jump/halt/conditional-halt and gates the register-file write strobe.
module program_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   stepMode,
  input  logic                   stepReq,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic [7:0]             condData,
  output logic [ADDR_WIDTH-1:0]  instrAddress,
  output logic                   execStrobe,
  output logic                   regWriteGate,
  output logic                   running,
  output logic                   halted,
  output logic                   paused,
  output logic [CNT_WIDTH-1:0]   retiredCount
);

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  stop_seen_q, stop_seen_d;
  logic                  exec_q, exec_d;
  logic                  running_q, running_d;
  logic                  halted_q, halted_d;
  logic                  paused_q, paused_d;
  logic                  cnt_clear;
  logic                  do_halt;

  logic [3:0] opcode;
  logic       cond_nz;
  logic       unused_instr_bits;

  assign opcode            = instruction[15:12];
  assign cond_nz           = |condData;
  assign unused_instr_bits = ^instruction[11:8];

  // Next-state, next-PC and registered status flags.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stop_seen_d = 1'b0;
    cnt_clear   = 1'b0;
    do_halt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d   = ST_FETCH;
          pc_d      = '0;
          cnt_clear = 1'b1;
        end
      end
      ST_FETCH: begin
        state_d     = ST_EXECUTE;
        stop_seen_d = stop;
      end
      ST_EXECUTE: begin
        case (opcode)
          OP_JUMP:  pc_d = ADDR_WIDTH'(instruction[7:0]);
          OP_HALT:  do_halt = 1'b1;
          OP_CHALT: begin
            if (cond_nz) do_halt = 1'b1;
            else         pc_d = pc_q + 1'b1;
          end
          default:  pc_d = pc_q + 1'b1;
        endcase
        // A stop seen during FETCH is remembered so the instruction completes first.
        if (do_halt)                   state_d = ST_HALTED;
        else if (stop || stop_seen_q)  state_d = ST_IDLE;
        else if (stepMode)             state_d = ST_PAUSE;
        else                           state_d = ST_FETCH;
      end
      ST_PAUSE: begin
        if (stop)                          state_d = ST_IDLE;
        else if (stepReq || !stepMode)     state_d = ST_FETCH;
      end
      ST_HALTED: begin
        if (start) begin
          state_d   = ST_FETCH;
          pc_d      = '0;
          cnt_clear = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    exec_d    = (state_d == ST_EXECUTE);
    running_d = (state_d == ST_FETCH) || (state_d == ST_EXECUTE) || (state_d == ST_PAUSE);
    halted_d  = (state_d == ST_HALTED);
    paused_d  = (state_d == ST_PAUSE);
  end

  // FSM state, PC and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      stop_seen_q <= 1'b0;
      exec_q      <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stop_seen_q <= stop_seen_d;
      exec_q      <= exec_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      paused_q    <= paused_d;
    end
  end

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_retired (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (exec_q),
    .count  (retiredCount)
  );

  assign instrAddress = pc_q;
  assign execStrobe   = exec_q;
  // Instruction data is only valid in EXECUTE, so the gate is qualified there.
  assign regWriteGate = exec_q && op_write_enable(opcode, cond_nz);
  assign running      = running_q;
  assign halted       = halted_q;
  assign paused       = paused_q;

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        stepMode = 1'b0;
  logic        stepReq = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [7:0]  condData;
  logic [7:0]  instrAddress;
  logic        execStrobe;
  logic        regWriteGate;
  logic        running;
  logic        halted;
  logic        paused;
  logic [15:0] retiredCount;

  logic [15:0] rom [256];
  logic [7:0]  creg [16];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] addr;
    logic       gate;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [7:0]  cval;
    logic        exp_gate;
    logic [7:0]  exp_pc;
    logic        exp_halt;
  } vec_t;
  vec_t vecs [10];

  program_sequencer #(
    .ADDR_WIDTH(8),
    .INSTR_WIDTH(16),
    .CNT_WIDTH(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .stepMode     (stepMode),
    .stepReq      (stepReq),
    .instruction  (instruction),
    .condData     (condData),
    .instrAddress (instrAddress),
    .execStrobe   (execStrobe),
    .regWriteGate (regWriteGate),
    .running      (running),
    .halted       (halted),
    .paused       (paused),
    .retiredCount (retiredCount)
  );

  always #5 clk = ~clk;

  // Synchronous ROM and register-file read model
  always @(posedge clk) instruction <= rom[instrAddress];
  assign condData = creg[instruction[3:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any executing instruction.
  task automatic tick();
    sb_entry_t e;
    @(negedge clk);
    if (execStrobe) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_exec actual=exec_at_%0h required=no_exec", instrAddress);
      end else begin
        e = sb_q.pop_front();
        check("sb_exec_addr", {24'd0, instrAddress}, {24'd0, e.addr});
        check("sb_write_gate", {31'd0, regWriteGate}, {31'd0, e.gate});
      end
    end
  endtask

  task automatic push(input logic [7:0] a, input logic g);
    sb_entry_t e;
    e.addr = a;
    e.gate = g;
    sb_q.push_back(e);
  endtask

  task automatic settle(input string name);
    int n = 0;
    while (!(paused || halted) && n < 30) begin
      tick();
      n++;
    end
    check(name, {31'd0, (paused || halted)}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_step();
    stepReq = 1'b1; tick(); stepReq = 1'b0;
  endtask

  initial begin
    logic ok;
    int   n;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 16; i++) creg[i] = 8'h00;

    vecs[0] = '{8'h04, 16'h3123, 8'h00, 1'b0, 8'h05, 1'b0};
    vecs[1] = '{8'h04, 16'h3123, 8'h07, 1'b1, 8'h05, 1'b0};
    vecs[2] = '{8'h04, 16'hF002, 8'h00, 1'b0, 8'h05, 1'b0};
    vecs[3] = '{8'h04, 16'hF002, 8'h01, 1'b0, 8'h04, 1'b1};
    vecs[4] = '{8'h04, 16'hD010, 8'h00, 1'b0, 8'h10, 1'b0};
    vecs[5] = '{8'h04, 16'hC000, 8'h05, 1'b0, 8'h05, 1'b0};
    vecs[6] = '{8'h04, 16'h0105, 8'h00, 1'b1, 8'h05, 1'b0};
    vecs[7] = '{8'h04, 16'hE000, 8'h00, 1'b0, 8'h04, 1'b1};
    vecs[8] = '{8'hFF, 16'h7AB0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[9] = '{8'h04, 16'hD0FF, 8'h00, 1'b0, 8'hFF, 1'b0};

    // Reset state
    tick(); tick();
    check("reset_outputs",
          {9'd0, instrAddress, execStrobe, regWriteGate, running, halted, paused},
          32'd0);
    check("reset_count", {16'd0, retiredCount}, 32'd0);
    rst = 1'b0;
    tick();

    // Free-run three-instruction program ending in halt
    rom[0] = 16'h0105; rom[1] = 16'h0203; rom[2] = 16'hE000;
    push(8'h00, 1'b1); push(8'h01, 1'b1); push(8'h02, 1'b0);
    pulse_start();
    settle("run_to_halt");
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_not_running", {31'd0, running}, 32'd0);
    check("halt_pc", {24'd0, instrAddress}, 32'h02);
    check("halt_count", {16'd0, retiredCount}, 32'd3);
    stop = 1'b1; tick(); stop = 1'b0; tick();
    check("halted_ignores_stop", {30'd0, halted, instrAddress == 8'h02}, 32'd3);

    // Single instructions reached via a jump, in step mode
    stepMode = 1'b1;
    for (int v = 0; v < 10; v++) begin
      rom[0] = 16'hD000 | {8'h00, vecs[v].addr};
      rom[vecs[v].addr] = vecs[v].instr;
      creg[vecs[v].instr[3:0]] = vecs[v].cval;
      push(8'h00, 1'b0);
      push(vecs[v].addr, vecs[v].exp_gate);
      pulse_start();
      settle("vec_jump_settle");
      check("vec_jump_pc", {24'd0, instrAddress}, {24'd0, vecs[v].addr});
      pulse_step();
      settle("vec_settle");
      check("vec_next_pc", {24'd0, instrAddress}, {24'd0, vecs[v].exp_pc});
      check("vec_halted", {31'd0, halted}, {31'd0, vecs[v].exp_halt});
      check("vec_paused", {31'd0, paused}, {31'd0, !vecs[v].exp_halt});
      check("vec_count", {16'd0, retiredCount}, 32'd2);
      if (paused) begin
        stop = 1'b1; tick(); stop = 1'b0; tick();
        check("vec_stop_idle", {31'd0, running}, 32'd0);
      end
    end

    // Step mode: stable pause, one instruction per stepReq, stop beats stepReq
    rom[0] = 16'h1000; rom[1] = 16'h2000; rom[2] = 16'h4000;
    push(8'h00, 1'b1); push(8'h01, 1'b1); push(8'h02, 1'b1);
    pulse_start();
    settle("step_settle0");
    check("step_pc0", {24'd0, instrAddress}, 32'h01);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!paused || instrAddress != 8'h01) ok = 1'b0;
    end
    check("pause_stable", {31'd0, ok}, 32'd1);
    pulse_step();
    settle("step_settle1");
    check("step_pc1", {24'd0, instrAddress}, 32'h02);
    check("step_count1", {16'd0, retiredCount}, 32'd2);
    pulse_step();
    settle("step_settle2");
    check("step_pc2", {24'd0, instrAddress}, 32'h03);
    check("step_count2", {16'd0, retiredCount}, 32'd3);
    stop = 1'b1; stepReq = 1'b1; tick(); stop = 1'b0; stepReq = 1'b0;
    tick(); tick();
    check("stop_over_step", {29'd0, running, paused, halted}, 32'd0);
    check("stop_pc_held", {24'd0, instrAddress}, 32'h03);
    pulse_step(); tick(); tick();
    check("stepreq_in_idle", {31'd0, running}, 32'd0);
    stepMode = 1'b0;

    // Free-run stop during FETCH: current instruction still completes
    rom[0] = 16'h1000; rom[1] = 16'h1000;
    push(8'h00, 1'b1);
    pulse_start();
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    check("fetch_stop_idle", {31'd0, running}, 32'd0);
    check("fetch_stop_pc", {24'd0, instrAddress}, 32'h01);
    check("fetch_stop_count", {16'd0, retiredCount}, 32'd1);

    // Asynchronous reset in the middle of EXECUTE
    rom[0] = 16'h1000; rom[1] = 16'h0105;
    push(8'h00, 1'b1);
    pulse_start();
    n = 0;
    while (retiredCount != 16'd1 && n < 10) begin
      tick();
      n++;
    end
    check("pre_reset_count", {16'd0, retiredCount}, 32'd1);
    @(posedge clk); #1;
    check("pre_reset_exec", {30'd0, execStrobe, regWriteGate}, 32'd3);
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {9'd0, instrAddress, execStrobe, regWriteGate, running, halted, paused},
          32'd0);
    check("async_reset_count", {16'd0, retiredCount}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Simultaneous start and stop in IDLE
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    tick(); tick();
    check("start_stop_idle", {29'd0, running, paused, halted}, 32'd0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Execution controller for the 8-bit, 16-bit-instruction CPU. It owns the program counter and the fetch/execute state machine, and presents addresses to the synchronous instruction ROM. It decides jump, halt and conditional-halt outcomes, and produces a gated register-write strobe that resolves conditional copy against real register data. It sits between the instruction ROM, the instruction decoder and the register file.

Parameters:
ADDR_WIDTH, 8, program counter / ROM address width
INSTR_WIDTH, 16, instruction width
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin execution at address 0
stop  in  1  one-cycle pulse; return to IDLE after current instruction
stepMode  in  1  level; 1 = pause after every instruction
stepReq  in  1  one-cycle pulse; advance one instruction while paused
instruction  in  INSTR_WIDTH  ROM read data, valid the cycle after instrAddress is presented
condData  in  8  register-file read data for register index instruction[3:0]
instrAddress  out  ADDR_WIDTH  program counter driven to ROM
execStrobe  out  1  high for exactly the EXECUTE cycle of each instruction
regWriteGate  out  1  register-file write enable qualifier for the EXECUTE cycle
running  out  1  high in FETCH, EXECUTE or PAUSE
halted  out  1  high in HALTED
paused  out  1  high in PAUSE
retiredCount  out  CNT_WIDTH  instructions executed since last start, saturating

Behaviour:
- Reset values: state IDLE, instrAddress 0, execStrobe 0, regWriteGate 0, running 0, halted 0, paused 0, retiredCount 0.
- States: IDLE, FETCH, EXECUTE, PAUSE, HALTED. All outputs are registered or decoded from state; no combinational path from start/stop to outputs.
- IDLE: start -> FETCH, PC<=0, retiredCount<=0. If start and stop arrive together, stop wins and the state stays IDLE.
- FETCH (1 cycle): instrAddress=PC is held; ROM registers the word. Always -> EXECUTE.
- EXECUTE (1 cycle): instruction is valid. execStrobe=1 and retiredCount increments (saturates at all-ones). Outcome by opcode instruction[15:12]:
  - 4'hD jump: PC<=instruction[7:0]; regWriteGate=0.
  - 4'hE halt: -> HALTED; PC holds the halt address; regWriteGate=0.
  - 4'hF conditional halt: if condData!=0 -> HALTED with PC held; otherwise PC<=PC+1. regWriteGate=0 in both cases.
  - 4'h3 conditional copy: regWriteGate=(condData!=0); PC<=PC+1.
  - 4'hC (unused): regWriteGate=0; PC<=PC+1.
  - all others: regWriteGate=1; PC<=PC+1.
- PC arithmetic is modulo 2^ADDR_WIDTH: 0xFF+1 wraps to 0x00.
- Next state from EXECUTE, unless the instruction halted:
  - stop seen in FETCH or EXECUTE -> IDLE (the current instruction still completes);
  - else if stepMode=1 -> PAUSE;
  - else -> FETCH.
- PAUSE: stepReq or stepMode=0 -> FETCH. stop -> IDLE. stop has priority over stepReq. stepReq outside PAUSE is ignored.
- HALTED: PC and retiredCount hold. start -> FETCH with PC<=0 and retiredCount<=0. stop is ignored.
- start in FETCH, EXECUTE or PAUSE is ignored.
- regWriteGate and execStrobe are 0 in every state other than EXECUTE.
- Asynchronous reset mid-instruction: returns to IDLE immediately. The pending write is never issued.
- Throughput: 2 cycles per instruction in free-run mode.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_CCOPY=4'h3, OP_JUMP=4'hD, OP_HALT=4'hE, OP_CHALT=4'hF) and the sequencer state encoding. The instruction decoder also uses these constants.
- One natural sub-module: sat_counter (CNT_WIDTH, clear, enable, saturate), used for retiredCount.

Test Plan:
- ROM 0:0x0105, 1:0x0203, 2:0xE000; start pulse -> addresses 0,1,2 on alternate cycles, execStrobe 3 times, halted=1, instrAddress=2, retiredCount=3.
- 0x3123 at PC 4 with condData=0 -> regWriteGate=0, PC=5. Repeat with condData=0x07 -> regWriteGate=1.
- 0xF002 with condData=0 -> PC advances. With condData=0x01 -> HALTED, instrAddress held, running=0.
- Jump 0xD0FF, then a non-control instruction at 0xFF -> next fetch address 0x00 (wrap). Jump 0xD010 -> next fetch 0x10.
- stepMode=1: after each EXECUTE, paused=1 and PC stays stable for 20 cycles. Each stepReq pulse advances exactly one instruction. stop while paused -> IDLE.
- Assert rst during EXECUTE -> all outputs 0 the same cycle, no write strobe. Simultaneous start and stop in IDLE -> stays IDLE.
